// File: rtl/lnzd_sparse_expander_if.sv
// Sparse-in / dense-out link of the LNZD expander.
// master = pair source and frame consumer, slave = expander.
interface lnzd_sparse_expander_if #(
    parameter int POS_WIDTH  = 4,
    parameter int DATA_WIDTH = 16
);
    localparam int NUM_ELEM = 1 << POS_WIDTH;

    logic                           in_valid;
    logic                           in_ready;
    logic [POS_WIDTH-1:0]           in_position;
    logic [DATA_WIDTH-1:0]          in_data;
    logic                           in_last;
    logic                           in_null;
    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_ELEM*DATA_WIDTH-1:0] out_vector;
    logic [NUM_ELEM-1:0]            out_mask;
    logic [POS_WIDTH:0]             out_count;
    logic                           err_order;

    modport master (
        output in_valid, in_position, in_data, in_last, in_null, out_ready,
        input  in_ready, out_valid, out_vector, out_mask, out_count, err_order
    );

    modport slave (
        input  in_valid, in_position, in_data, in_last, in_null, out_ready,
        output in_ready, out_valid, out_vector, out_mask, out_count, err_order
    );
endinterface

// File: rtl/lnzd_sparse_expander.sv
// Rebuilds a dense vector from ascending (position, value) pairs and hands it out on valid/ready.
// Optional LNZD_EXPAND_ORDER_CHECK_EN adds the sticky non-ascending-position flag err_order.
//
// state   | meaning
// COLLECT | accepting pairs into the buffer, in_ready=1
// OUTPUT  | dense frame presented, out_valid=1, waiting for out_ready
module lnzd_sparse_expander #(
    parameter int POS_WIDTH  = 4,
    parameter int DATA_WIDTH = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    lnzd_sparse_expander_if.slave bus
);
    localparam int NUM_ELEM = 1 << POS_WIDTH;

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_t;

    state_t                         state;
    logic                           in_ready_q;
    logic                           out_valid_q;
    logic [NUM_ELEM*DATA_WIDTH-1:0] vector_q;
    logic [NUM_ELEM-1:0]            mask_q;
    logic [POS_WIDTH:0]             count_q;

    logic accept;
    logic write_en;
    logic frame_done;

    assign accept     = bus.in_valid & in_ready_q;
    assign write_en   = accept & ~bus.in_null;
    assign frame_done = (state == OUTPUT) & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            vector_q    <= '0;
            mask_q      <= '0;
            count_q     <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (write_en) begin
                        vector_q[bus.in_position*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
                        mask_q[bus.in_position] <= 1'b1;
                        // duplicates overwrite data but are counted once
                        if (!mask_q[bus.in_position]) begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                    if (accept && bus.in_last) begin
                        state       <= OUTPUT;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        state       <= COLLECT;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        vector_q    <= '0;
                        mask_q      <= '0;
                        count_q     <= '0;
                    end
                end
                default: begin
                    state       <= COLLECT;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_vector = vector_q;
    assign bus.out_mask   = mask_q;
    assign bus.out_count  = count_q;

`ifdef LNZD_EXPAND_ORDER_CHECK_EN
    logic [POS_WIDTH-1:0] last_pos_q;
    logic                 first_q;
    logic                 err_q;

    // Null pairs carry no position, so they neither advance nor test the order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pos_q <= '0;
            first_q    <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            if (write_en) begin
                if (!first_q && (bus.in_position <= last_pos_q)) begin
                    err_q <= 1'b1;
                end
                last_pos_q <= bus.in_position;
                first_q    <= 1'b0;
            end
            if (frame_done) begin
                first_q <= 1'b1;
            end
        end
    end

    assign bus.err_order = err_q;
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done;
    assign bus.err_order     = 1'b0;
`endif
endmodule

// File: tb/tb_lnzd_sparse_expander.sv
// Directed bench for lnzd_sparse_expander: table of pairs with hand-computed frame results,
// plus hand sequences for reset, backpressure, full frame and ordering.
module tb_lnzd_sparse_expander;
    localparam int PW = 4;
    localparam int DW = 16;
    localparam int NE = 1 << PW;
    localparam int VW = NE * DW;
`ifdef LNZD_EXPAND_ORDER_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lnzd_sparse_expander_if #(.POS_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

    lnzd_sparse_expander #(.POS_WIDTH(PW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [PW-1:0] pos;
        logic [DW-1:0] data;
        logic          last;
        logic          nul;
        logic [NE-1:0] exp_mask;
        logic [PW:0]   exp_count;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_vec [NE];

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] flat();
        logic [VW-1:0] r;
        for (int i = 0; i < NE; i++) r[i*DW +: DW] = exp_vec[i];
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NE; i++) exp_vec[i] = '0;
    endtask

    task automatic send_pair(input logic [PW-1:0] pos, input logic [DW-1:0] data,
                             input logic last, input logic nul);
        int guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready stayed %b, required 1", bus.in_ready);
        end
        bus.in_valid    = 1'b1;
        bus.in_position = pos;
        bus.in_data     = data;
        bus.in_last     = last;
        bus.in_null     = nul;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_null  = 1'b0;
        if (!nul) exp_vec[pos] = data;
    endtask

    // Checks the presented frame, then handshakes it and checks the return to COLLECT.
    task automatic finish_frame(input string name, input logic [NE-1:0] m, input logic [PW:0] c);
        check({name, "_out_valid"}, VW'(bus.out_valid), VW'(1'b1));
        check({name, "_out_mask"},  VW'(bus.out_mask),  VW'(m));
        check({name, "_out_count"}, VW'(bus.out_count), VW'(c));
        check({name, "_out_vector"}, bus.out_vector, flat());
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({name, "_post_valid"}, VW'(bus.out_valid), VW'(1'b0));
        check({name, "_post_ready"}, VW'(bus.in_ready),  VW'(1'b1));
        check({name, "_post_mask"},  VW'(bus.out_mask),  VW'(0));
        check({name, "_post_count"}, VW'(bus.out_count), VW'(0));
        clear_model();
    endtask

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{4'd1,  16'h0011, 1'b0, 1'b0, 16'h0000, 5'd0};
        tbl[1]  = '{4'd5,  16'h0055, 1'b0, 1'b0, 16'h0000, 5'd0};
        tbl[2]  = '{4'd15, 16'hFFFF, 1'b1, 1'b0, 16'h8022, 5'd3};
        tbl[3]  = '{4'd7,  16'hDEAD, 1'b1, 1'b1, 16'h0000, 5'd0};
        tbl[4]  = '{4'd0,  16'h1234, 1'b1, 1'b0, 16'h0001, 5'd1};
        tbl[5]  = '{4'd2,  16'h00AA, 1'b0, 1'b0, 16'h0000, 5'd0};
        tbl[6]  = '{4'd7,  16'h0077, 1'b0, 1'b0, 16'h0000, 5'd0};
        tbl[7]  = '{4'd12, 16'h00CC, 1'b1, 1'b0, 16'h1084, 5'd3};
        tbl[8]  = '{4'd4,  16'h0044, 1'b0, 1'b0, 16'h0000, 5'd0};
        tbl[9]  = '{4'd9,  16'hBAD0, 1'b0, 1'b1, 16'h0000, 5'd0};
        tbl[10] = '{4'd9,  16'h0099, 1'b1, 1'b0, 16'h0210, 5'd2};
        tbl[11] = '{4'd10, 16'h0000, 1'b1, 1'b0, 16'h0400, 5'd1};

        bus.in_valid    = 1'b0;
        bus.in_position = '0;
        bus.in_data     = '0;
        bus.in_last     = 1'b0;
        bus.in_null     = 1'b0;
        bus.out_ready   = 1'b0;
        clear_model();

        #12;
        check("rst_in_ready",  VW'(bus.in_ready),  VW'(1'b1));
        check("rst_out_valid", VW'(bus.out_valid), VW'(1'b0));
        check("rst_out_mask",  VW'(bus.out_mask),  VW'(0));
        check("rst_out_count", VW'(bus.out_count), VW'(0));
        check("rst_err_order", VW'(bus.err_order), VW'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-frame after three pairs discards the partial frame
        send_pair(4'd1, 16'h0101, 1'b0, 1'b0);
        send_pair(4'd2, 16'h0202, 1'b0, 1'b0);
        send_pair(4'd3, 16'h0303, 1'b0, 1'b0);
        check("partial_out_valid", VW'(bus.out_valid), VW'(1'b0));
        check("partial_mask",      VW'(bus.out_mask),  VW'(16'h000E));
        check("partial_count",     VW'(bus.out_count), VW'(3));
        #2;
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", VW'(bus.out_valid), VW'(1'b0));
        check("midrst_out_mask",  VW'(bus.out_mask),  VW'(0));
        check("midrst_out_count", VW'(bus.out_count), VW'(0));
        check("midrst_in_ready",  VW'(bus.in_ready),  VW'(1'b1));
        check("midrst_vector",    bus.out_vector,     VW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            send_pair(tbl[i].pos, tbl[i].data, tbl[i].last, tbl[i].nul);
            if (tbl[i].last) begin
                finish_frame($sformatf("tbl%0d", i), tbl[i].exp_mask, tbl[i].exp_count);
            end else begin
                check($sformatf("tbl%0d_no_early_valid", i), VW'(bus.out_valid), VW'(1'b0));
            end
        end

        // Backpressure: frame held while out_ready low, competing pair ignored
        send_pair(4'd3, 16'h0033, 1'b1, 1'b0);
        bus.in_valid    = 1'b1;
        bus.in_position = 4'd8;
        bus.in_data     = 16'hBEEF;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_out_valid", k), VW'(bus.out_valid), VW'(1'b1));
            check($sformatf("bp%0d_in_ready", k),  VW'(bus.in_ready),  VW'(1'b0));
            check($sformatf("bp%0d_mask", k),      VW'(bus.out_mask),  VW'(16'h0008));
            check($sformatf("bp%0d_vector", k),    bus.out_vector,     flat());
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        finish_frame("bp_frame", 16'h0008, 5'd1);
        send_pair(4'd0, 16'h0101, 1'b1, 1'b0);
        finish_frame("bp_next", 16'h0001, 5'd1);

        for (int p = 0; p < NE; p++) begin
            send_pair(PW'(p), 16'h1000 + 16'(p), (p == NE - 1), 1'b0);
        end
        finish_frame("full", 16'hFFFF, 5'd16);
        check("ascending_err_order", VW'(bus.err_order), VW'(1'b0));

        send_pair(4'd4, 16'hAAAA, 1'b0, 1'b0);
        send_pair(4'd2, 16'hBBBB, 1'b1, 1'b0);
        check("order_err", VW'(bus.err_order), VW'(EXP_ERR));
        finish_frame("order", 16'h0014, 5'd2);

        send_pair(4'd3, 16'hA0A0, 1'b0, 1'b0);
        send_pair(4'd3, 16'hB0B0, 1'b1, 1'b0);
        check("dup_err", VW'(bus.err_order), VW'(EXP_ERR));
        finish_frame("dup", 16'h0008, 5'd1);

        send_pair(4'd6, 16'h0666, 1'b1, 1'b0);
        check("sticky_err", VW'(bus.err_order), VW'(EXP_ERR));
        finish_frame("after_err", 16'h0040, 5'd1);

        #2;
        rst_n = 1'b0;
        #2;
        check("final_rst_err_order", VW'(bus.err_order), VW'(1'b0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule
